load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 188 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding access, byte/half/word with lane steering,
// sign/zero extension on loads, and a bounded wait for read data.
module load_store_unit #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic [1:0]       rsp_cause,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam int         CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic               is_load_q, is_load_d;
  logic [2:0]         func3_q, func3_d;
  logic [WIDTH-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [1:0]         cause_q, cause_d;

  logic               in_is_load, in_is_store, in_legal, in_misaligned;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [WIDTH-1:0]   ld_data;

  // Decode of the incoming request, evaluated while IDLE.
  always_comb begin
    in_is_load  = (opcode == OPC_LOAD);
    in_is_store = (opcode == OPC_STORE);
    in_legal    = 1'b0;
    if (in_is_load)
      in_legal = (func3 == 3'b000) || (func3 == 3'b001) || (func3 == 3'b010) ||
                 (func3 == 3'b100) || (func3 == 3'b101);
    else if (in_is_store)
      in_legal = (func3 == 3'b000) || (func3 == 3'b001) || (func3 == 3'b010);
    in_misaligned = ((func3[1:0] == 2'b01) && addr[0]) ||
                    ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  end

  always_comb begin
    case (addr_q[1:0])
      2'b00:   ld_byte = mem_rdata[7:0];
      2'b01:   ld_byte = mem_rdata[15:8];
      2'b10:   ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (func3_q)
      3'b000:  ld_data = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{(WIDTH-16){ld_half[15]}}, ld_half};
      3'b100:  ld_data = {{(WIDTH-8){1'b0}}, ld_byte};
      3'b101:  ld_data = {{(WIDTH-16){1'b0}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    is_load_d = is_load_q;
    func3_d   = func3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cause_d   = cause_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && (in_is_load || in_is_store)) begin
          is_load_d = in_is_load;
          func3_d   = func3;
          addr_d    = addr;
          wdata_d   = wdata;
          cnt_d     = '0;
          rdata_d   = '0;
          err_d     = 1'b0;
          cause_d   = 2'b00;
          if (!in_legal) begin
            err_d   = 1'b1;
            cause_d = 2'b10;
            state_d = S_RESP;
          end else if (in_misaligned) begin
            err_d   = 1'b1;
            cause_d = 2'b01;
            state_d = S_RESP;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          cnt_d   = '0;
          state_d = is_load_q ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        // Read data in the expiry cycle takes priority over the timeout.
        if (mem_rvalid) begin
          rdata_d = ld_data;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          cause_d = 2'b11;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      is_load_q <= 1'b0;
      func3_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cause_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
      func3_q   <= func3_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      cause_q   <= cause_d;
    end
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    rsp_rdata = (state_q == S_RESP) ? rdata_q : '0;
    rsp_err   = (state_q == S_RESP) ? err_q : 1'b0;
    rsp_cause = (state_q == S_RESP) ? cause_q : 2'b00;
    mem_req   = (state_q == S_REQ);
    mem_we    = !is_load_q;
    mem_addr  = {addr_q[WIDTH-1:2], 2'b00};
    case (func3_q[1:0])
      2'b00: begin
        mem_be    = 4'b0001 << addr_q[1:0];
        mem_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        mem_be    = 4'b1111;
        mem_wdata = wdata_q;
      end
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit against a transaction-level model.
module tb_load_store_unit;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  rsp_cause;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .opcode(opcode), .func3(func3), .addr(addr), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_cause(rsp_cause),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * (a % 4))) & 32'hFF;
    h = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  task automatic check_idle(input string tag);
    check_val({tag, "_ready"}, 32'(req_ready), 32'd1);
    check_val({tag, "_rspv"}, 32'(rsp_valid), 32'd0);
    check_val({tag, "_memreq"}, 32'(mem_req), 32'd0);
  endtask

  // Called at a negedge with the unit idle; returns at the negedge after the response.
  task automatic run_txn(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int gnt_dly, input int rv_dly,
                         input logic [31:0] rd);
    bit          is_ld, is_st, legal, misal;
    int          size, n_wait;
    logic [1:0]  exp_cause;
    logic [31:0] exp_be, exp_wd, exp_rd;
    is_ld = (opc == 7'b0000011);
    is_st = (opc == 7'b0100011);
    size  = 1 << (f3 % 4);
    legal = is_ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    misal = (a % size) != 0;
    exp_be = ((32'd1 << size) - 1) << (a % 4);
    exp_wd = (size == 1) ? wd[7:0] * 32'h0101_0101 :
             (size == 2) ? wd[15:0] * 32'h0001_0001 : wd;

    check_val("accept_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; opcode = opc; func3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; opcode = $urandom; func3 = $urandom; addr = $urandom; wdata = $urandom;

    if (!is_ld && !is_st) begin
      check_idle("ignored_op");
      return;
    end

    if (!legal || misal) begin
      exp_cause = !legal ? 2'b10 : 2'b01;
      check_val("err_rspv", 32'(rsp_valid), 32'd1);
      check_val("err_flag", 32'(rsp_err), 32'd1);
      check_val("err_cause", 32'(rsp_cause), 32'(exp_cause));
      check_val("err_rdata", rsp_rdata, 32'd0);
      check_val("err_memreq", 32'(mem_req), 32'd0);
      @(negedge clk);
      check_idle("after_err");
      return;
    end

    for (int k = 0; k <= gnt_dly; k++) begin
      check_val("req_memreq", 32'(mem_req), 32'd1);
      check_val("req_rspv", 32'(rsp_valid), 32'd0);
      check_val("req_we", 32'(mem_we), 32'(is_st));
      check_val("req_addr", mem_addr, a & 32'hFFFF_FFFC);
      if (is_st) begin
        check_val("req_be", 32'(mem_be), exp_be);
        check_val("req_wdata", mem_wdata, exp_wd);
      end
      mem_gnt    = (k == gnt_dly);
      mem_rvalid = $urandom_range(0, 1);
      mem_rdata  = $urandom;
      @(negedge clk);
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;

    if (is_ld) begin
      n_wait = (rv_dly < TIMEOUT) ? rv_dly + 1 : TIMEOUT;
      for (int w = 0; w < n_wait; w++) begin
        check_val("wait_rspv", 32'(rsp_valid), 32'd0);
        check_val("wait_memreq", 32'(mem_req), 32'd0);
        mem_rvalid = (w == rv_dly);
        mem_rdata  = (w == rv_dly) ? rd : $urandom;
        @(negedge clk);
      end
      mem_rvalid = 1'b0;
      exp_rd = (rv_dly < TIMEOUT) ? model_load(f3, a, rd) : 32'd0;
      check_val("ld_rspv", 32'(rsp_valid), 32'd1);
      check_val("ld_rdata", rsp_rdata, exp_rd);
      check_val("ld_err", 32'(rsp_err), 32'(rv_dly >= TIMEOUT));
      check_val("ld_cause", 32'(rsp_cause), (rv_dly < TIMEOUT) ? 32'd0 : 32'd3);
    end else begin
      check_val("st_rspv", 32'(rsp_valid), 32'd1);
      check_val("st_rdata", rsp_rdata, 32'd0);
      check_val("st_err", 32'(rsp_err), 32'd0);
      check_val("st_cause", 32'(rsp_cause), 32'd0);
    end
    // Bus strobes during the response cycle must have no effect.
    mem_gnt = $urandom_range(0, 1); mem_rvalid = $urandom_range(0, 1);
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    check_idle("after_rsp");
  endtask

  initial begin
    logic [6:0] opc;
    rst = 1'b1; req_valid = 1'b0; opcode = '0; func3 = '0; addr = '0; wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    check_val("reset_err", 32'(rsp_err), 32'd0);
    check_val("reset_cause", 32'(rsp_cause), 32'd0);
    check_val("reset_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_txn(7'b0000011, 3'b000, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_1234);
    run_txn(7'b0100011, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 2, 0, 32'h0);
    run_txn(7'b0000011, 3'b010, 32'h0000_3001, 32'h0, 0, 0, 32'h0);
    run_txn(7'b0000011, 3'b101, 32'h0000_3002, 32'h0, 1, 2, 32'h8001_0000);
    run_txn(7'b0000011, 3'b011, 32'h0000_4000, 32'h0, 0, 0, 32'h0);
    run_txn(7'b0110011, 3'b000, 32'h0000_4000, 32'h0, 0, 0, 32'h0);
    run_txn(7'b0100011, 3'b000, 32'h0000_5003, 32'h0000_005A, 0, 0, 32'h0);
    run_txn(7'b0100011, 3'b010, 32'h0000_5004, 32'hDEAD_BEEF, 1, 0, 32'h0);
    run_txn(7'b0000011, 3'b010, 32'h0000_6000, 32'h0, 0, TIMEOUT, 32'h0);
    run_txn(7'b0000011, 3'b001, 32'h0000_6002, 32'h0, 0, TIMEOUT - 1, 32'h9876_1234);

    // Reset in the middle of a read wait, with read data arriving afterwards.
    req_valid = 1'b1; opcode = 7'b0000011; func3 = 3'b010; addr = 32'h40; wdata = '0;
    @(negedge clk);
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle("midwait_rst");
    check_val("midwait_rst_rdata", rsp_rdata, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("late_rvalid");
    mem_rvalid = 1'b0;
    @(negedge clk);
    check_idle("post_rst_idle");
    run_txn(7'b0000011, 3'b100, 32'h0000_7001, 32'h0, 0, 1, 32'hA5C3_F00F);

    for (int i = 0; i < 80; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      opc = (sel == 0) ? 7'b0110011 : (sel < 5) ? 7'b0000011 : 7'b0100011;
      if ($urandom_range(0, 3) == 0) begin
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = $urandom;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        check_idle("idle_strobes");
      end
      run_txn(opc, 3'($urandom_range(0, 7)), $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 4), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
